// File: rtl/hex_display_if.sv
// Display bus between a word source (master) and the 8-digit hex scanner (slave).
// The master presents value/hold and observes the multiplexed digit drives.
interface hex_display_if;
    logic [31:0] value;
    logic        hold;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (output value, hold, input an, seg, dp, frame_tick);
    modport slave  (input value, hold, output an, seg, dp, frame_tick);
endinterface

// File: rtl/hex_display_driver.sv
// Time-multiplexed 8-digit hex display scanner with frame-synchronous shadow
// capture, optional leading-zero blanking and a freeze (hold) mode.
module hex_display_driver #(
    parameter int REFRESH_DIV = 1000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    hex_display_if.slave  dsp
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          frozen_q, frozen_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_tick_q, frame_tick_d;

    logic          tick, wrap, blanked;
    logic [7:0]    lz;
    logic [3:0]    nib;

    function automatic logic [6:0] hex_pat(input logic [3:0] n);
        case (n)
            4'h0: hex_pat = 7'h3F;
            4'h1: hex_pat = 7'h06;
            4'h2: hex_pat = 7'h5B;
            4'h3: hex_pat = 7'h4F;
            4'h4: hex_pat = 7'h66;
            4'h5: hex_pat = 7'h6D;
            4'h6: hex_pat = 7'h7D;
            4'h7: hex_pat = 7'h07;
            4'h8: hex_pat = 7'h7F;
            4'h9: hex_pat = 7'h6F;
            4'hA: hex_pat = 7'h77;
            4'hB: hex_pat = 7'h7C;
            4'hC: hex_pat = 7'h39;
            4'hD: hex_pat = 7'h5E;
            4'hE: hex_pat = 7'h79;
            default: hex_pat = 7'h71;
        endcase
    endfunction

    assign tick = (presc_q == PW'(REFRESH_DIV - 1));
    assign wrap = tick && (idx_q == 3'd7);

    always_comb begin
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = tick ? idx_q + 3'd1 : idx_q;
        shadow_d     = shadow_q;
        frozen_d     = frozen_q;
        // The displayed word and freeze state only change at the frame wrap,
        // so a scan never mixes two words.
        if (wrap) begin
            shadow_d = dsp.hold ? shadow_q : dsp.value;
            frozen_d = dsp.hold;
        end

        lz = '0;
        for (int i = 1; i < 8; i++)
            lz[i] = ((shadow_q >> (4 * i)) == 32'd0);
        blanked = BLANK_LZ && lz[idx_q];
        nib     = shadow_q[{idx_q, 2'b00} +: 4];

        an_d         = blanked ? 8'hFF : ~(8'd1 << idx_q);
        seg_d        = blanked ? 7'h7F : ~hex_pat(nib);
        dp_d         = ~((idx_q == 3'd0) && frozen_q);
        frame_tick_d = wrap;
    end

    // idx resets to 7 so the very first tick is a frame wrap that loads value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q      <= '0;
            idx_q        <= 3'd7;
            shadow_q     <= '0;
            frozen_q     <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            frozen_q     <= frozen_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign dsp.an         = an_q;
    assign dsp.seg        = seg_q;
    assign dsp.dp         = dp_q;
    assign dsp.frame_tick = frame_tick_q;
endmodule

// File: doc/hex_display_driver.md
HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 1000: clocks per digit slot; legal range 1..65535.
REQ-002 Parameter BLANK_LZ, default 1: 1 = blank leading-zero digits, 0 = show all eight digits.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 value  input  32  register word to display (CPU register x3 output); sampled only at frame boundaries.
REQ-006 hold  input  1  1 = freeze the displayed word; value is ignored while high.
REQ-007 an  output  8  digit enables, active-low, bit i = hex digit i (digit 0 = value[3:0]).
REQ-008 seg  output  7  segments, active-low, bit0 = a ... bit6 = g.
REQ-009 dp  output  1  decimal point, active-low.
REQ-010 frame_tick  output  1  one-cycle pulse when a new frame starts.

Function
REQ-011 Prescaler counts 0..REFRESH_DIV-1 and wraps; the wrap cycle is a "tick"; REFRESH_DIV=1 gives a tick every cycle.
REQ-012 Digit index idx (3 bits) increments mod 8 on each tick; each digit is lit for exactly REFRESH_DIV cycles.
REQ-013 On a tick where idx goes 7->0: the shadow register loads value if hold=0 and keeps its contents if hold=1; frame_tick=1 in the following cycle only.
REQ-014 value changes between frame boundaries SHALL NOT affect the display (no tearing).
REQ-015 an, seg, dp and frame_tick are registered; they reflect idx/shadow with exactly 1 clock of latency.
REQ-016 an: exactly one bit low (bit idx) unless that digit is blanked, in which case an=8'hFF.
REQ-017 seg = bitwise inverse of active-high gfedcba pattern for nibble shadow[4*idx+3:4*idx]: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-018 Blanking: when BLANK_LZ=1, digit i (i>=1) is blanked if shadow[31:4i]==0; digit 0 is never blanked; a blanked digit drives seg=7'h7F.
REQ-019 dp=0 only while idx==0 and the hold register state is frozen (hold sampled high at the last frame boundary); otherwise dp=1.
REQ-020 hold toggling mid-frame takes effect only at the next 7->0 wrap.
REQ-021 Frame period = 8*REFRESH_DIV cycles; frame_tick pulses with exactly that spacing.

Reset
REQ-022 While rst=0: prescaler=0, idx=7, shadow=32'h0, frozen flag=0, an=8'hFF, seg=7'h7F, dp=1, frame_tick=0, asynchronously and immediately.
REQ-023 After rst rises, the first tick wraps idx 7->0 and loads shadow from value (hold permitting); reset mid-scan restarts this sequence, with no partial frame retained.

Verification
REQ-024 REFRESH_DIV=4, BLANK_LZ=1, value=32'h1234ABCD, hold=0 -> after first frame: idx0 an=8'hFE seg=7'h21; idx7 an=8'h7F seg=7'h79; each digit held 4 cycles; frame_tick every 32 cycles.
REQ-025 value=32'h000000F0 -> digit0 seg=7'h40, digit1 seg=7'h0E, digits 2-7 an=8'hFF seg=7'h7F; with BLANK_LZ=0, digits 2-7 show seg=7'h40.
REQ-026 value changes 32'h11111111 -> 32'h22222222 while idx=3 -> digits 4-7 still show 1 (7'h79); 2 (7'h24) appears from the next frame onward.
REQ-027 hold=1 before a wrap, then value=32'hFFFFFFFF -> old word persists and dp=0 on idx0; hold=0 -> F (7'h0E) on all digits starting the next frame, and dp=1.
REQ-028 rst pulled low at idx=5, mid-digit -> same cycle an=8'hFF seg=7'h7F dp=1 frame_tick=0; after release, the first frame_tick occurs REFRESH_DIV+1 cycles later.
REQ-029 REFRESH_DIV=1 -> idx advances every cycle; frame_tick every 8 cycles; no digit skipped.
